// File: rtl/gru_hidden_streamer_if.sv
// Valid/ready stream carrying one hidden-state element per beat, tagged with its index
// and a last flag on the final element of the vector.
interface gru_hidden_streamer_if #(
  parameter int unsigned H          = 16,
  parameter int unsigned DATA_WIDTH = 15
) ();
  localparam int unsigned IdxW = $clog2(H);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [IdxW-1:0]       m_index;
  logic                  m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_index,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_index,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/gru_hidden_streamer.sv
// Captures the GRU hidden state on done_i, feeds it back as h_prev_o and serialises it,
// element 0 first, onto a valid/ready stream with registered outputs.
module gru_hidden_streamer #(
  parameter int unsigned H          = 16,
  parameter int unsigned DATA_WIDTH = 15,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             done_i,
  input  logic [H-1:0][DATA_WIDTH-1:0]     h_t_i,
  output logic [H-1:0][DATA_WIDTH-1:0]     h_prev_o,
  gru_hidden_streamer_if.master            m_if,
  output logic                             busy_o,
  output logic                             overrun_o,
  input  logic                             clear_overrun_i,
  output logic [CNT_WIDTH-1:0]             frame_count_o
);

  localparam int unsigned IdxW = $clog2(H);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e                          state_q, state_d;
  logic [IdxW-1:0]                 idx_q, idx_d;
  logic [H-1:0][DATA_WIDTH-1:0]    buf_q, buf_d;
  logic [H-1:0][DATA_WIDTH-1:0]    h_prev_q, h_prev_d;
  logic                            valid_q, valid_d;
  logic [DATA_WIDTH-1:0]           data_q, data_d;
  logic                            last_q, last_d;
  logic                            overrun_q, overrun_d;
  logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;

  logic                            handshake;
  logic                            final_hs;
  logic                            accept;
  logic                            drop;
  logic [IdxW-1:0]                 idx_inc;

  assign handshake = valid_q & m_if.m_ready;
  // last_q is only ever set while streaming the final element.
  assign final_hs  = handshake & last_q;
  assign idx_inc   = idx_q + IdxW'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    h_prev_d  = h_prev_q;
    valid_d   = valid_q;
    data_d    = data_q;
    last_d    = last_q;
    overrun_d = overrun_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    drop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        accept = done_i;
      end
      StStream: begin
        // A new vector fits only in the slot freed by the final handshake.
        accept = done_i & final_hs;
        drop   = done_i & ~final_hs;
        if (final_hs) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: ;
    endcase

    if (accept) begin
      state_d  = StStream;
      buf_d    = h_t_i;
      h_prev_d = h_t_i;
      idx_d    = '0;
      valid_d  = 1'b1;
      data_d   = h_t_i[0];
      last_d   = 1'b0;
    end else if (final_hs) begin
      state_d = StIdle;
      idx_d   = '0;
      valid_d = 1'b0;
      data_d  = '0;
      last_d  = 1'b0;
    end else if (handshake) begin
      idx_d  = idx_inc;
      data_d = buf_q[idx_inc];
      last_d = (idx_inc == IdxW'(H - 1));
    end

    if (drop) begin
      overrun_d = 1'b1;
    end else if (clear_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      buf_q     <= '0;
      h_prev_q  <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      h_prev_q  <= h_prev_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m_if.m_valid  = valid_q;
  assign m_if.m_data   = data_q;
  assign m_if.m_index  = idx_q;
  assign m_if.m_last   = last_q;
  assign h_prev_o      = h_prev_q;
  assign busy_o        = (state_q == StStream);
  assign overrun_o     = overrun_q;
  assign frame_count_o = cnt_q;

  // A stalled word must stay put until the consumer takes it.
  a_hold_stalled: assert property (@(posedge clk) disable iff (!rst_n)
    (m_if.m_valid && !m_if.m_ready) |=>
      (m_if.m_valid && $stable(m_if.m_data) && $stable(m_if.m_index) && $stable(m_if.m_last)));

  a_last_at_end: assert property (@(posedge clk) disable iff (!rst_n)
    m_if.m_last |-> (m_if.m_index == IdxW'(H - 1)));

endmodule

// File: tb/tb_gru_hidden_streamer.sv
// Bench for gru_hidden_streamer: table-driven scenarios, reset/wrap sequences and random
// traffic, all checked every cycle against a queue-based model of the expected stream.
module tb_gru_hidden_streamer;
  localparam int unsigned H  = 16;
  localparam int unsigned DW = 15;
  localparam int unsigned CW = 16;
  localparam int unsigned IW = $clog2(H);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 done;
  logic                 clr;
  logic [H-1:0][DW-1:0] h_t;
  logic [H-1:0][DW-1:0] h_prev;
  logic [H-1:0][DW-1:0] h_prev_s;
  logic                 busy, ovr, busy_s, ovr_s;
  logic [CW-1:0]        cnt;
  logic [3:0]           cnt_s;

  gru_hidden_streamer_if #(.H(H), .DATA_WIDTH(DW)) m_if ();
  gru_hidden_streamer_if #(.H(H), .DATA_WIDTH(DW)) s_if ();

  gru_hidden_streamer #(.H(H), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .done_i          (done),
    .h_t_i           (h_t),
    .h_prev_o        (h_prev),
    .m_if            (m_if),
    .busy_o          (busy),
    .overrun_o       (ovr),
    .clear_overrun_i (clr),
    .frame_count_o   (cnt)
  );

  // Narrow-counter copy so the wrap to zero is reachable within a short run.
  gru_hidden_streamer #(.H(H), .DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_w4 (
    .clk             (clk),
    .rst_n           (rst_n),
    .done_i          (done),
    .h_t_i           (h_t),
    .h_prev_o        (h_prev_s),
    .m_if            (s_if),
    .busy_o          (busy_s),
    .overrun_o       (ovr_s),
    .clear_overrun_i (clr),
    .frame_count_o   (cnt_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } word_t;

  typedef struct {
    int          base;
    int          stp;
    logic [3:0]  rdy_pat;
    int          done2_at;
    int          done2_base;
    logic [DW-1:0] exp_first;
    int          exp_frames;
    logic        exp_ovr;
  } vec_t;

  word_t                exp_q[$];
  int unsigned          m_cnt;
  logic                 m_ovr;
  logic [H-1:0][DW-1:0] m_hprev;
  int                   n_cmp = 0;
  int                   n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt   = 0;
    m_ovr   = 1'b0;
    m_hprev = '0;
  endtask

  // Spec rules: a vector is taken when nothing is pending or the last word leaves this cycle.
  task automatic model_update();
    bit hs, fin, empty_before, dropped;
    if (!rst_n) begin
      model_reset();
      return;
    end
    empty_before = (exp_q.size() == 0);
    hs           = !empty_before && m_if.m_ready;
    fin          = hs && (exp_q.size() == 1);
    dropped      = 1'b0;
    if (hs) void'(exp_q.pop_front());
    if (fin) m_cnt++;
    if (done) begin
      if (empty_before || fin) begin
        for (int i = 0; i < H; i++) begin
          exp_q.push_back('{data: h_t[i], idx: IW'(i), last: (i == H - 1)});
        end
        m_hprev = h_t;
      end else begin
        dropped = 1'b1;
      end
    end
    if (dropped) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic check_outputs();
    chk("m_valid", m_if.m_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("m_data", m_if.m_data, exp_q[0].data);
      chk("m_index", m_if.m_index, exp_q[0].idx);
      chk("m_last", m_if.m_last, exp_q[0].last);
    end
    chk("busy", busy, exp_q.size() != 0);
    chk("overrun", ovr, m_ovr);
    chk("frame_count", cnt, m_cnt[CW-1:0]);
    chk("frame_count_w4", cnt_s, m_cnt[3:0]);
    chk("h_prev", h_prev, m_hprev);
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_ready(input logic r);
    m_if.m_ready = r;
    s_if.m_ready = r;
  endtask

  task automatic load_vec(input int base, input int stp);
    for (int i = 0; i < H; i++) h_t[i] = DW'(base + stp * i);
  endtask

  vec_t        recs[5];
  int unsigned cnt0;
  int          c;
  int          guard;
  bit          fired;

  initial begin
    recs[0] = '{1, 1, 4'b1111, -1, 0, 15'd1, 1, 1'b0};
    recs[1] = '{-1, -1, 4'b1111, -1, 0, 15'h7FFF, 1, 1'b0};
    recs[2] = '{1, 1, 4'b1001, -1, 0, 15'd1, 1, 1'b0};
    recs[3] = '{1, 1, 4'b1111, 5, 200, 15'd1, 1, 1'b1};
    recs[4] = '{1, 1, 4'b1111, 15, 100, 15'd1, 2, 1'b0};

    rst_n = 1'b0;
    done  = 1'b0;
    clr   = 1'b0;
    h_t   = '0;
    set_ready(1'b0);
    model_reset();
    #3;
    chk("rst_valid", m_if.m_valid, 0);
    chk("rst_data", m_if.m_data, 0);
    chk("rst_index", m_if.m_index, 0);
    chk("rst_last", m_if.m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", ovr, 0);
    chk("rst_count", cnt, 0);
    chk("rst_h_prev", h_prev, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int r = 0; r < 5; r++) begin
      cnt0 = m_cnt;
      load_vec(recs[r].base, recs[r].stp);
      done = 1'b1;
      set_ready(1'b1);
      step();
      done = 1'b0;
      chk("first_word", m_if.m_data, recs[r].exp_first);
      c     = 0;
      fired = 1'b0;
      for (guard = 0; guard < 300; guard++) begin
        set_ready(recs[r].rdy_pat[c % 4]);
        if (recs[r].done2_at >= 0 && !fired && exp_q.size() != 0 &&
            exp_q[0].idx == IW'(recs[r].done2_at)) begin
          load_vec(recs[r].done2_base, 1);
          done  = 1'b1;
          fired = 1'b1;
        end
        step();
        done = 1'b0;
        c++;
        if (exp_q.size() == 0) break;
      end
      if (guard >= 300) begin
        n_cmp++;
        n_fail++;
        $display("FAIL stream_timeout: record %0d still pending, required completion", r);
      end
      chk("idle_after", m_if.m_valid, 0);
      chk("frames", cnt, CW'(cnt0 + recs[r].exp_frames));
      chk("overrun_end", ovr, recs[r].exp_ovr);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("overrun_clr", ovr, 0);
    end

    // Reset mid-stream at word 7, after a dropped vector has set overrun.
    load_vec(50, 1);
    done = 1'b1;
    set_ready(1'b1);
    step();
    done = 1'b0;
    for (guard = 0; guard < 40 && exp_q.size() != 0 && exp_q[0].idx != IW'(7); guard++) begin
      if (exp_q[0].idx == IW'(3)) begin
        load_vec(300, 1);
        done = 1'b1;
      end
      step();
      done = 1'b0;
    end
    chk("ovr_before_rst", ovr, 1);
    chk("index_before_rst", m_if.m_index, 7);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", m_if.m_valid, 0);
    chk("arst_data", m_if.m_data, 0);
    chk("arst_index", m_if.m_index, 0);
    chk("arst_last", m_if.m_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overrun", ovr, 0);
    chk("arst_count", cnt, 0);
    chk("arst_h_prev", h_prev, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("valid_after_rst", m_if.m_valid, 0);

    // Back-to-back frames until the 4-bit counter wraps.
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
    set_ready(1'b1);
    for (guard = 0; guard < 400 && m_cnt < 16; guard++) begin
      for (int i = 0; i < H; i++) h_t[i] = DW'($urandom);
      done = (exp_q.size() <= 1);
      step();
    end
    done = 1'b0;
    chk("wrap_w4", cnt_s, 0);
    chk("count16", cnt, 16);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < H; i++) h_t[i] = DW'($urandom);
      done = ($urandom_range(0, 11) == 0);
      clr  = ($urandom_range(0, 19) == 0);
      set_ready($urandom_range(0, 9) < 7);
      step();
    end
    done = 1'b0;
    clr  = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
